spi_byte_receiver: RTL and testbench

SPI_BYTE_RECEIVER -- requirements
Module: spi_byte_receiver

---
 rtl/spi_byte_receiver.sv | 184 ++++++++++++++++++
 tb/tb_spi_byte_receiver.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_receiver.sv
// spi_byte_receiver
//   Receives LSB-first bytes from an SPI-style transmitter whose clock is
//   asynchronous to clk, and queues them in a first-word-fall-through FIFO.
//
// Parameters
//   DEPTH        FIFO depth in bytes (power of two, 2..16)
//   SYNC_STAGES  synchronizer flops per serial input (>= 2)
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   rst        asynchronous reset, active-low
//   sclk_in    serial clock from the transmitter (asynchronous)
//   en_in      frame enable, active-low
//   data_in    serial data, sampled on sclk rise, LSB first
//   rd         pop request for the FIFO head
//   out_byte   FIFO head byte (0x00 while empty)
//   out_valid  FIFO not empty
//   full       FIFO holds DEPTH bytes
//   busy       receiver is inside a frame
//   frame_err  one-cycle pulse when a frame ends mid-byte
//   overflow   sticky flag: a byte was dropped on a full FIFO
module spi_byte_receiver #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_in,
  input  logic       en_in,
  input  logic       data_in,
  input  logic       rd,
  output logic [7:0] out_byte,
  output logic       out_valid,
  output logic       full,
  output logic       busy,
  output logic       frame_err,
  output logic       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // Synchronizers: reset to the idle line levels so reset never looks like
  // a frame start or a clock edge.
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] en_sync_q,   en_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   s_sclk, s_en, s_data, rise;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  // Only the seven most recently received bits need to be held; the eighth
  // comes straight from s_data on the completing rise.
  logic [6:0] shift_q, shift_d;
  logic       frame_err_q, frame_err_d;
  logic       push_req;
  logic [7:0] push_byte;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             fifo_full, fifo_nempty, push, pop;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
    en_sync_d   = {en_sync_q[SYNC_STAGES-2:0],   en_in};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], data_in};
    s_sclk      = sclk_sync_q[SYNC_STAGES-1];
    s_en        = en_sync_q[SYNC_STAGES-1];
    s_data      = data_sync_q[SYNC_STAGES-1];
    sclk_prev_d = s_sclk;
    rise        = s_sclk & ~sclk_prev_q;
  end

  // Receive FSM
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push_req    = 1'b0;
    push_byte   = {s_data, shift_q};
    case (state_q)
      IDLE: begin
        if (!s_en) begin
          state_d   = RECV;
          bit_cnt_d = 3'd0;
        end
      end
      RECV: begin
        if (s_en) begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
          // A byte completing on the very cycle the frame ends still counts.
          if (rise && bit_cnt_q == 3'd7) begin
            push_req = 1'b1;
            shift_d  = push_byte[7:1];
          end else begin
            frame_err_d = (bit_cnt_q != 3'd0);
          end
        end else if (rise) begin
          shift_d   = push_byte[7:1];
          bit_cnt_d = bit_cnt_q + 3'd1;
          push_req  = (bit_cnt_q == 3'd7);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO control: a push on a full FIFO is only accepted when a pop frees
  // the slot on the same edge.
  always_comb begin
    fifo_full   = (count_q == FULL_CNT);
    fifo_nempty = (count_q != '0);
    pop         = rd & fifo_nempty;
    push        = push_req & (~fifo_full | pop);
    overflow_d  = overflow_q | (push_req & fifo_full & ~pop);
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      en_sync_q   <= '1;
      data_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      en_sync_q   <= en_sync_d;
      data_sync_q <= data_sync_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: out_byte is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_byte;
    end
  end

  always_comb begin
    out_valid = fifo_nempty;
    out_byte  = fifo_nempty ? mem_q[rd_ptr_q] : 8'h00;
    full      = fifo_full;
    busy      = (state_q == RECV);
    frame_err = frame_err_q;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_spi_byte_receiver.sv
module tb_spi_byte_receiver;

  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic       clk, rst, sclk_in, en_in, data_in, rd;
  logic [7:0] out_byte;
  logic       out_valid, full, busy, frame_err, overflow;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;

  logic [7:0] model_q[$];
  logic       exp_ovf = 1'b0;

  spi_byte_receiver #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .sclk_in(sclk_in), .en_in(en_in),
    .data_in(data_in), .rd(rd), .out_byte(out_byte),
    .out_valid(out_valid), .full(full), .busy(busy),
    .frame_err(frame_err), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
  end

  // One sclk period = 8 clk cycles; data changes while sclk is low.
  task automatic send_bit(input logic b);
    @(negedge clk);
    sclk_in = 1'b0;
    data_in = b;
    repeat (4) @(negedge clk);
    sclk_in = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    if (model_q.size() < DEPTH) model_q.push_back(v);
    else exp_ovf = 1'b1;
  endtask

  task automatic frame_start();
    @(negedge clk);
    en_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk);
    sclk_in = 1'b0;
    en_in   = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_pop();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (out_byte !== 8'h00 || out_valid !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_fifo out_byte=%h out_valid=%b full=%b expected 00 0 0", out_byte, out_valid, full);
    end
    checks++;
    if (busy !== 1'b0 || frame_err !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl busy=%b frame_err=%b overflow=%b expected 0 0 0", busy, frame_err, overflow);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    int fe0;
    fe0 = fe_cnt;
    frame_start();
    send_byte(8'hA5);
    checks++;
    if (out_valid !== 1'b1 || out_byte !== model_q[0]) begin
      errors++;
      $display("FAIL single_head out_valid=%b out_byte=%h expected 1 %h", out_valid, out_byte, model_q[0]);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy busy=%b expected 1", busy);
    end
    frame_end();
    checks++;
    if (busy !== 1'b0 || fe_cnt != fe0) begin
      errors++;
      $display("FAIL single_end busy=%b frame_errs=%0d expected 0 0", busy, fe_cnt - fe0);
    end
    do_pop();
    void'(model_q.pop_front());
    checks++;
    if (out_valid !== 1'b0 || out_byte !== 8'h00) begin
      errors++;
      $display("FAIL single_pop out_valid=%b out_byte=%h expected 0 00", out_valid, out_byte);
    end
  endtask

  task automatic test_back_to_back();
    frame_start();
    send_byte(8'h3C);
    send_byte(8'hC3);
    frame_end();
    checks++;
    if (full !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_occ full=%b out_valid=%b expected 0 1", full, out_valid);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_byte !== model_q[0]) begin
        errors++;
        $display("FAIL b2b_byte%0d out_byte=%h expected %h", k, out_byte, model_q[0]);
      end
      do_pop();
      void'(model_q.pop_front());
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_cnt;
    frame_start();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    frame_end();
    checks++;
    if (fe_cnt - fe0 != 1) begin
      errors++;
      $display("FAIL ferr_pulses count=%0d expected 1", fe_cnt - fe0);
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ferr_state out_valid=%b busy=%b expected 0 0", out_valid, busy);
    end
    frame_start();
    send_byte(8'h7E);
    frame_end();
    checks++;
    if (out_valid !== 1'b1 || out_byte !== model_q[0] || fe_cnt - fe0 != 1) begin
      errors++;
      $display("FAIL ferr_next out_valid=%b out_byte=%h pulses=%0d expected 1 %h 1", out_valid, out_byte, fe_cnt - fe0, model_q[0]);
    end
    do_pop();
    void'(model_q.pop_front());
  endtask

  task automatic test_full_pop();
    logic [7:0] v;
    frame_start();
    for (int k = 0; k < DEPTH; k++) send_byte(8'h10 + 8'(k));
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL fullpop_fill full=%b expected 1", full);
    end
    v = 8'h55;
    for (int i = 0; i < 7; i++) send_bit(v[i]);
    @(negedge clk);
    sclk_in = 1'b0;
    data_in = v[7];
    repeat (4) @(negedge clk);
    sclk_in = 1'b1;
    // rd lands on the clk edge that pushes the final byte.
    repeat (SYNC) @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    void'(model_q.pop_front());
    model_q.push_back(v);
    frame_end();
    checks++;
    if (overflow !== 1'b0 || full !== 1'b1) begin
      errors++;
      $display("FAIL fullpop_flags overflow=%b full=%b expected 0 1", overflow, full);
    end
    for (int k = 0; k < DEPTH; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_byte !== model_q[0]) begin
        errors++;
        $display("FAIL fullpop_byte%0d out_valid=%b out_byte=%h expected 1 %h", k, out_valid, out_byte, model_q[0]);
      end
      do_pop();
      void'(model_q.pop_front());
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_empty out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    frame_start();
    for (int k = 1; k <= 5; k++) send_byte(8'(k));
    frame_end();
    checks++;
    if (full !== 1'b1 || overflow !== exp_ovf) begin
      errors++;
      $display("FAIL ovf_flags full=%b overflow=%b expected 1 %b", full, overflow, exp_ovf);
    end
    for (int k = 0; k < DEPTH; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_byte !== model_q[0]) begin
        errors++;
        $display("FAIL ovf_byte%0d out_valid=%b out_byte=%h expected 1 %h", k, out_valid, out_byte, model_q[0]);
      end
      do_pop();
      void'(model_q.pop_front());
    end
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after out_valid=%b overflow=%b expected 0 1", out_valid, overflow);
    end
  endtask

  task automatic test_reset_mid();
    int fe0;
    frame_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    fe0 = fe_cnt;
    rst = 1'b0;
    #1;
    model_q.delete();
    exp_ovf = 1'b0;
    checks++;
    if (out_byte !== 8'h00 || out_valid !== 1'b0 || full !== 1'b0 ||
        busy !== 1'b0 || frame_err !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs byte=%h vld=%b full=%b busy=%b ferr=%b ovf=%b expected all 0",
               out_byte, out_valid, full, busy, frame_err, overflow);
    end
    repeat (3) @(negedge clk);
    sclk_in = 1'b0;
    en_in   = 1'b1;
    data_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (fe_cnt != fe0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_release pulses=%0d out_valid=%b busy=%b expected 0 0 0", fe_cnt - fe0, out_valid, busy);
    end
    frame_start();
    send_byte(8'h81);
    frame_end();
    checks++;
    if (out_valid !== 1'b1 || out_byte !== model_q[0]) begin
      errors++;
      $display("FAIL rstmid_next out_valid=%b out_byte=%h expected 1 %h", out_valid, out_byte, model_q[0]);
    end
  endtask

  initial begin
    rst     = 1'b0;
    sclk_in = 1'b0;
    en_in   = 1'b1;
    data_in = 1'b0;
    rd      = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_full_pop();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
